fpa_int_encoder: RTL and testbench

Sequential converter from 8-bit two's-complement integer to the 8-bit minifloat format used by the floating-point adder: sign in bit 7, biased exponent in [6:3], fraction in [2:0] with a hidden leading 1. It sits in front of the adder's operand inputs and produces `a`/`b` operands from integer sources. It is the producer-side counterpart of the adder's result format. It normalizes with a multi-cycle shift FSM under a start/done handshake and reports zero and inexact exceptions.

---
 rtl/fpa_int_encoder.sv | 133 +++++++++++++
 tb/tb_fpa_int_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fpa_int_encoder.sv
// -----------------------------------------------------------------------------
// fpa_int_encoder
//   Converts an 8-bit two's-complement integer into the 8-bit minifloat operand
//   format of the floating-point adder: {sign, exp[3:0], mant[2:0]} with a
//   hidden leading 1. Normalisation is a one-bit-per-cycle left shift under a
//   start/done handshake. Rounding truncates the magnitude; any dropped bits
//   raise the inexact flag. Zero is encoded as all zeros with the zero flag set.
//
// Parameters
//   BIAS        exponent bias, legal range 1..8 (BIAS + 7 must fit in 4 bits)
//
// Ports
//   clk         system clock, rising edge
//   clr         asynchronous active-low reset
//   start       conversion request, honoured only in IDLE
//   din         signed integer, captured on the edge that accepts start
//   ans         registered minifloat result, held until the next result
//   ans_except  [0] zero, [1] inexact, [3:2] reserved (0); registered with ans
//   busy        high in LOAD and NORM
//   done        one-cycle pulse in DONE; ans is valid from this cycle on
//   state       debug view of the FSM: IDLE=0, LOAD=1, NORM=2, DONE=3
// -----------------------------------------------------------------------------
module fpa_int_encoder #(
  parameter int BIAS = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] din,
  output logic [7:0] ans,
  output logic [3:0] ans_except,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // Exponent of a value whose leading 1 is already in bit 7 (no shifts done).
  localparam logic [3:0] EXP_TOP = 4'(BIAS + 7);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] in_reg;
  logic       sign;
  logic [7:0] mag;
  logic [2:0] cnt;
  logic [3:0] exp_val;

  // Every left shift moves the leading 1 one place up, so the exponent drops
  // by one per shift taken.
  assign exp_val = EXP_TOP - {1'b0, cnt};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the hold value is assigned before the case so that no path leaves
  // state_d unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)         state_d = LOAD;
      LOAD: state_d = (in_reg == 8'd0) ? DONE : NORM;
      NORM: if (mag[7])        state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the working registers are reset as well as the outputs, so an
  // aborted conversion leaves no residue that could leak into a later result.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      in_reg     <= 8'd0;
      sign       <= 1'b0;
      mag        <= 8'd0;
      cnt        <= 3'd0;
      ans        <= 8'd0;
      ans_except <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) in_reg <= din;
        end
        LOAD: begin
          sign <= in_reg[7];
          // Negating -128 wraps back to 8'h80, which is the correct magnitude.
          mag  <= in_reg[7] ? 8'(~in_reg + 8'd1) : in_reg;
          cnt  <= 3'd0;
          if (in_reg == 8'd0) begin
            ans        <= 8'h00;
            ans_except <= 4'b0001;
          end
        end
        NORM: begin
          if (!mag[7]) begin
            mag <= mag << 1;
            cnt <= cnt + 3'd1;
          end else begin
            // Bit 7 is the hidden 1; the next three bits are kept and the
            // rest are truncated, only flagging inexact.
            ans        <= {sign, exp_val, mag[6:4]};
            ans_except <= {2'b00, |mag[3:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == LOAD) || (state_q == NORM);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_fpa_int_encoder.sv
// -----------------------------------------------------------------------------
// tb_fpa_int_encoder
//   Self-checking bench for fpa_int_encoder with BIAS = 7. Expected results come
//   from an arithmetic model (absolute value, position of the highest set bit,
//   integer division for the kept mantissa and a remainder test for inexact).
// -----------------------------------------------------------------------------
module tb_fpa_int_encoder;

  localparam int BIAS = 7;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] din;
  logic [7:0] ans;
  logic [3:0] ans_except;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  fpa_int_encoder #(.BIAS(BIAS)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .din       (din),
    .ans       (ans),
    .ans_except(ans_except),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flags and cycles from accept edge to DONE.
  function automatic void ref_model(input logic [7:0] v, output logic [7:0] a,
                                    output logic [3:0] e, output int lat);
    int x, m, p, k, ex, mant;
    logic inexact;
    x = int'($signed(v));
    m = (x < 0) ? -x : x;
    if (m == 0) begin
      a = 8'h00; e = 4'b0001; lat = 2;
      return;
    end
    p = 0;
    while ((1 << (p + 1)) <= m) p++;
    k    = 7 - p;
    ex   = BIAS + 7 - k;
    mant = ((m * 8) >> p) - 8;
    inexact = (p > 3) && ((m % (1 << (p - 3))) != 0);
    a   = {x < 0, 4'(ex), 3'(mant)};
    e   = {2'b00, inexact, 1'b0};
    lat = 3 + k;
  endfunction

  // One conversion from IDLE; called at a negedge with the DUT in IDLE.
  task automatic run_conv(input logic [7:0] v, output logic [7:0] a,
                          output logic [3:0] e, output int lat);
    logic [7:0] a_prev;
    logic [3:0] e_prev;
    bit         held;
    a_prev = ans;
    e_prev = ans_except;
    held   = 1'b1;
    din    = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = 8'($urandom);
    lat   = 1;
    check("load_state", 32'(state), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    while (!done && lat < 20) begin
      if (ans !== a_prev || ans_except !== e_prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("ans_held_until_done", 32'(held), 32'd1);
    a = ans;
    e = ans_except;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(state), 32'd0);
  endtask

  initial begin : stim
    logic [7:0] a, ea;
    logic [3:0] e, ee;
    int         lat, el;
    logic [7:0] dir_v  [6] = '{8'h01, 8'h05, 8'hFF, 8'h80, 8'h7F, 8'h00};
    logic [7:0] dir_a  [6] = '{8'h38, 8'h4A, 8'hB8, 8'hF0, 8'h6F, 8'h00};
    logic [3:0] dir_e  [6] = '{4'h0,  4'h0,  4'h0,  4'h0,  4'h2,  4'h1};
    int         dir_l  [6] = '{10, 8, 10, 3, 4, 2};
    logic [7:0] pend_v [$];
    int         pend_t [$];
    int         cyc, dones, accepts, seen;
    bit         prev_done;

    // Reset state
    clr = 1'b0; start = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ans", 32'(ans), 32'h00);
    check("rst_except", 32'(ans_except), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Directed exact values, extremes and zero
    for (int i = 0; i < 6; i++) begin
      run_conv(dir_v[i], a, e, lat);
      check($sformatf("dir_ans_%02h", dir_v[i]), 32'(a), 32'(dir_a[i]));
      check($sformatf("dir_exc_%02h", dir_v[i]), 32'(e), 32'(dir_e[i]));
      check($sformatf("dir_lat_%02h", dir_v[i]), 32'(lat), 32'(dir_l[i]));
    end

    // Reset mid-NORM after a nonzero result is on the outputs
    run_conv(8'h5A, a, e, lat);
    din = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_norm", 32'(state), 32'd2);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("abort_ans", 32'(ans), 32'h00);
    check("abort_except", 32'(ans_except), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Exhaustive sweep against the model
    for (int i = 0; i < 256; i++) begin
      ref_model(8'(i), ea, ee, el);
      run_conv(8'(i), a, e, lat);
      check($sformatf("sweep_ans_%02h", i), 32'(a), 32'(ea));
      check($sformatf("sweep_exc_%02h", i), 32'(e), 32'(ee));
      check($sformatf("sweep_lat_%02h", i), 32'(lat), 32'(el));
    end

    // Handshake: start held high, din random every cycle
    cyc = 0; dones = 0; accepts = 0; prev_done = 1'b0;
    start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (done) begin
        dones++;
        check("hs_single_pulse", 32'(prev_done), 32'd0);
        if (pend_v.size() == 0) begin
          check("hs_spurious_done", 32'd1, 32'd0);
        end else begin
          ref_model(pend_v[0], ea, ee, el);
          check($sformatf("hs_ans_%02h", pend_v[0]), 32'(ans), 32'(ea));
          check($sformatf("hs_exc_%02h", pend_v[0]), 32'(ans_except), 32'(ee));
          check($sformatf("hs_lat_%02h", pend_v[0]), 32'(cyc - pend_t[0]), 32'(el));
          void'(pend_v.pop_front());
          void'(pend_t.pop_front());
        end
      end
      prev_done = done;
      din = 8'($urandom);
      if (state == 2'd0 && n < 280) begin
        pend_v.push_back(din);
        pend_t.push_back(cyc);
        accepts++;
      end
      if (n == 279) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("hs_done_count", 32'(dones), 32'(accepts));
    check("hs_drained", 32'(pend_v.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
